// File: rtl/shift_fwd_ctrl.sv
// shift_fwd_ctrl: ID/EX and EX/WB control for the 8-bit shifter.
// Handles operand bypass, EX forwarding select, write-back and a debug counter.
module shift_fwd_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [1:0] id_op,
   input  logic [2:0] id_rs,
   input  logic [2:0] id_rd,
   input  logic [2:0] id_shamt,
   input  logic [7:0] id_data1,
   input  logic [7:0] rf_b_data,
   input  logic       stall,
   input  logic       flush,
   input  logic [7:0] shift_result,
   output logic [2:0] sh_a,
   output logic [7:0] sh_b,
   output logic [7:0] sh_wb_result,
   output logic [7:0] sh_wb_data1,
   output logic [1:0] fwd_ctrl,
   output logic       wb_we,
   output logic [2:0] wb_addr,
   output logic [7:0] wb_data,
   output logic [7:0] fwd_count
);

   localparam logic [1:0] OP_SHL = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;

   localparam logic [1:0] FWD_RES = 2'b00;
   localparam logic [1:0] FWD_D1  = 2'b01;
   localparam logic [1:0] FWD_REG = 2'b10;

   logic       r_ex_valid;
   logic [1:0] r_ex_op;
   logic [2:0] r_ex_rs;
   logic [2:0] r_ex_rd;
   logic [2:0] r_ex_shamt;
   logic [7:0] r_ex_data1;
   logic [7:0] r_ex_b;

   logic       r_wb_valid;
   logic [1:0] r_wb_op;
   logic [2:0] r_wb_rd;
   logic [7:0] r_wb_res;
   logic [7:0] r_wb_data1;

   logic [7:0] r_fwd_count;

   logic       w_id_ok;
   logic [7:0] w_id_b;
   logic       w_match;
   logic [1:0] w_fwd;
   logic       w_cnt_inc;

   // Only shift and move occupy a slot; the register file is not
   // write-through, so a same-cycle write is bypassed into ex_b.
   assign w_id_ok = id_valid & ((id_op == OP_SHL) | (id_op == OP_MOV));
   assign w_id_b  = (r_wb_valid && (r_wb_rd == id_rs)) ? wb_data
                                                       : rf_b_data;

   assign w_match = r_ex_valid & (r_ex_op == OP_SHL) &
                    r_wb_valid & (r_wb_rd == r_ex_rs);

   // Forwarding select for the shifter operand mux
   always_comb begin
      w_fwd = FWD_REG;
      if (w_match && (r_wb_op == OP_SHL)) begin
         w_fwd = FWD_RES;
      end else if (w_match && (r_wb_op == OP_MOV)) begin
         w_fwd = FWD_D1;
      end
   end

   assign w_cnt_inc = r_ex_valid & (r_ex_op == OP_SHL) &
                      (w_fwd != FWD_REG) & (r_fwd_count != 8'hFF);

   // ID/EX register; flush only kills the instruction entering EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_op    <= 2'b00;
         r_ex_rs    <= 3'd0;
         r_ex_rd    <= 3'd0;
         r_ex_shamt <= 3'd0;
         r_ex_data1 <= 8'd0;
         r_ex_b     <= 8'd0;
      end else if (!stall) begin
         r_ex_valid <= w_id_ok & ~flush;
         r_ex_op    <= id_op;
         r_ex_rs    <= id_rs;
         r_ex_rd    <= id_rd;
         r_ex_shamt <= id_shamt;
         r_ex_data1 <= id_data1;
         r_ex_b     <= w_id_b;
      end
   end

   // EX/WB register captures the shifter result and the move operand
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_op    <= 2'b00;
         r_wb_rd    <= 3'd0;
         r_wb_res   <= 8'd0;
         r_wb_data1 <= 8'd0;
      end else if (!stall) begin
         r_wb_valid <= r_ex_valid;
         r_wb_op    <= r_ex_op;
         r_wb_rd    <= r_ex_rd;
         r_wb_res   <= shift_result;
         r_wb_data1 <= r_ex_data1;
      end
   end

   // Saturating count of shifts that took a forwarded operand
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_count <= 8'd0;
      end else if (!stall && w_cnt_inc) begin
         r_fwd_count <= r_fwd_count + 8'd1;
      end
   end

   assign sh_a         = r_ex_shamt;
   assign sh_b         = r_ex_b;
   assign sh_wb_result = r_wb_res;
   assign sh_wb_data1  = r_wb_data1;
   assign fwd_ctrl     = w_fwd;

   assign wb_we   = r_wb_valid;
   assign wb_addr = r_wb_rd;
   assign wb_data = (r_wb_op == OP_SHL) ? r_wb_res : r_wb_data1;

   assign fwd_count = r_fwd_count;

endmodule
